// File: rtl/arqt1_pio_ext.sv
// WIDTH-bit Avalon-MM general-purpose I/O port: per-bit direction, synchronised
// inputs, sticky edge capture, maskable interrupt and atomic set/clear of outputs.
module arqt1_pio_ext #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_OUT   = '0,
  parameter logic [WIDTH-1:0]     RESET_DIR   = '1,
  parameter int unsigned          EDGE_TYPE   = 0,
  parameter int unsigned          IRQ_TYPE    = 1,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  // Bus semantics: no handshake and no wait states. A write is accepted on every
  // edge where chipselect & ~write_n; readdata is refreshed on every edge from the
  // address seen at that edge, so a read presented in cycle k is valid after edge k.
  logic             write_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev;

  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] rd_val;
  logic             irq_next;

  assign write_en = chipselect & ~write_n;
  assign wdata    = writedata[WIDTH-1:0];
  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign out_port = data_out;
  assign oe       = dir;

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Input synchroniser plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= in_sync;
    end
  end

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0)      edge_hit = in_sync & ~prev;
    else if (EDGE_TYPE == 1) edge_hit = ~in_sync & prev;
    else                     edge_hit = in_sync ^ prev;
    edge_hit = edge_hit & ~dir;
  end

  always_comb begin
    edge_clr = '0;
    if (write_en && address == ADDR_EDGE) edge_clr = wdata;
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      mask     <= '0;
    end else if (write_en) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_DIR:    dir      <= wdata;
        ADDR_MASK:   mask     <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     ;
      endcase
    end
  end

  // A new edge on the same bit as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~edge_clr) | edge_hit;
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA: rd_val = (data_out & dir) | (in_sync & ~dir);
      ADDR_DIR:  rd_val = dir;
      ADDR_MASK: rd_val = mask;
      ADDR_EDGE: rd_val = edge_capture;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    if (IRQ_TYPE == 1) irq_next = |(edge_capture & mask);
    else               irq_next = |(in_sync & ~dir & mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= 32'(rd_val);
      irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_arqt1_pio_ext.sv
// Self-checking bench for arqt1_pio_ext (WIDTH=8, RESET_OUT=A5, rising-edge capture,
// edge-driven irq): register access, sync latency, capture/clear races, async reset.
module tb_arqt1_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic        rd_valid = 1'b0;

  arqt1_pio_ext #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF),
    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers: called at a negedge, return at the next negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    exp_q.push_back(exp);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  // Scoreboard: a read sampled at a posedge is compared at the following negedge.
  always @(posedge clk) rd_valid <= chipselect & write_n & reset_n;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) check("sb_extra_read", 32'(exp_q.size()), 32'd1);
      else check("readdata", readdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] model;
  int         op;
  logic [7:0] v;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'hA5);
    check("rst_oe", 32'(oe), 32'hFF);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    rd(3'd0, 32'hA5);

    // direction mix and sync latency
    wr(3'd1, 32'h0F);
    check("oe_0f", 32'(oe), 32'h0F);
    wr(3'd0, 32'hFF);
    check("out_ff", 32'(out_port), 32'hFF);
    in_port = 8'h30;
    repeat (2) @(negedge clk);
    rd(3'd0, 32'h3F);
    rd(3'd3, 32'h30);
    wr(3'd3, 32'hFF);
    rd(3'd3, 32'h00);

    // data / outset / outclr, back to back
    wr(3'd0, 32'h00);
    check("out_00", 32'(out_port), 32'h00);
    wr(3'd4, 32'h81);
    check("out_set81", 32'(out_port), 32'h81);
    wr(3'd5, 32'h01);
    check("out_clr01", 32'(out_port), 32'h80);
    wr(3'd6, 32'hFF);
    check("addr6_ignored", 32'(out_port), 32'h80);
    rd(3'd4, 32'h00);
    rd(3'd6, 32'h00);
    rd(3'd1, 32'h0F);

    // edge capture and irq timing on bit 2
    in_port = 8'h00;
    wr(3'd1, 32'h00);
    repeat (4) @(negedge clk);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h104);
    rd(3'd2, 32'h04);
    rd(3'd3, 32'h00);
    check("irq_idle", 32'(irq), 32'd0);
    in_port = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("irq_early", 32'(irq), 32'd0);
    end
    rd(3'd3, 32'h04);
    check("irq_set", 32'(irq), 32'd1);
    wr(3'd3, 32'h04);
    check("irq_hold_after_clr", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);

    // clear and new edge on the same cycle: edge wins
    in_port = 8'h05;
    repeat (2) @(negedge clk);
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h01);
    check("irq_unmasked_bit", 32'(irq), 32'd0);
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h00);

    // falling edges and output-direction bits do not capture
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    rd(3'd3, 32'h00);
    wr(3'd1, 32'h01);
    in_port = 8'h01;
    repeat (4) @(negedge clk);
    rd(3'd3, 32'h00);

    // async reset in the middle of a burst with irq high
    wr(3'd1, 32'h00);
    in_port = 8'h05;
    repeat (4) @(negedge clk);
    check("irq_pre_reset", 32'(irq), 32'd1);
    wr(3'd0, 32'h55);
    check("rd_pre_reset", readdata, 32'h05);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hAA;
    #2 reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'd0);
    check("async_readdata", readdata, 32'd0);
    check("async_out_port", 32'(out_port), 32'hA5);
    check("async_oe", 32'(oe), 32'hFF);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(3'd3, 32'h00);
    rd(3'd2, 32'h00);
    rd(3'd1, 32'hFF);
    rd(3'd0, 32'hA5);

    // random data/outset/outclr traffic against a reference
    model = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      v  = 8'($urandom_range(0, 255));
      op = $urandom_range(0, 2);
      case (op)
        0: begin wr(3'd0, {24'hFFFFFF, v}); model = v; end
        1: begin wr(3'd4, 32'(v)); model = model | v; end
        default: begin wr(3'd5, 32'(v)); model = model & ~v; end
      endcase
      check("rand_out_port", 32'(out_port), 32'(model));
      if (i % 3 == 0) rd(3'd0, 32'(model));
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arqt1_pio_ext.md
# arqt1_pio_ext

Parametrised general-purpose I/O port on the Avalon-MM slave bus. It generalises the 4-bit output-only PIO to WIDTH bits with per-bit direction, synchronised inputs, edge capture and a maskable interrupt. Atomic set/clear output registers are included. It sits beside the existing PIOs on the processor's data master and drives board LEDs/switches/buttons.

## Interface
- WIDTH, 8: port width, 1..32.
- RESET_OUT, 0: reset value of the output data register.
- RESET_DIR, all ones: reset value of the direction register (1 = output).
- EDGE_TYPE, 0: capture on 0 rising, 1 falling, 2 either edge.
- IRQ_TYPE, 1: 0 level-sensitive, 1 edge-capture driven.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.
- clk  in  1  single system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH are 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable (= direction register).
- irq  out  1  registered interrupt request, active high.

## Operation
- Write = chipselect & ~write_n. Reads have no side effects.
- Addr 0 DATA: write loads data_out. Read returns (data_out & dir) | (in_sync & ~dir).
- Addr 1 DIR: read/write direction register.
- Addr 2 MASK: read/write interrupt mask.
- Addr 3 EDGE: read edge_capture. A write clears every bit written as 1.
- Addr 4 OUTSET: write ORs writedata into data_out. Reads 0.
- Addr 5 OUTCLR: write clears data_out bits written as 1. Reads 0.
- Addr 6, 7: reads 0, writes ignored.
- Synchroniser: in_port passes through a SYNC_STAGES flop chain to give in_sync. prev is in_sync delayed one cycle.
- Edge per bit: rising = in_sync & ~prev, falling = ~in_sync & prev, either = XOR. Only bits with dir=0 set edge_capture.
- Capture bits are sticky until cleared by a write to EDGE.
- If a new edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- IRQ_TYPE=1: irq is the register of |(edge_capture & MASK).
- IRQ_TYPE=0: irq is the register of |(in_sync & ~dir & MASK).
- Reset values: data_out=RESET_OUT, dir=oe=RESET_DIR, MASK=0, edge_capture=0, sync chain=0, prev=0, readdata=0, irq=0.
- Sync chain and prev reset to 0, so an input held high through reset captures a rising edge after reset release. Software clears EDGE during init.
- Reset asserted mid-operation forces all reset values immediately, asynchronously.

## Timing
- Read latency is 1 cycle. readdata is registered every cycle from the address and state sampled at edge k, and is valid after edge k.
- Write takes effect at the edge where it is sampled. out_port/oe/MASK change after that edge.
- Read-after-write is valid if the read address is presented the cycle after the write.
- An in_port change stable before edge k appears on in_sync after edge k+SYNC_STAGES-1. edge_capture sets after edge k+SYNC_STAGES. irq asserts after edge k+SYNC_STAGES+1.
- A capture clear at edge k drops irq after edge k+1, provided no other masked capture bit is set.
- Back-to-back writes are allowed every cycle; no wait states.

## Test plan
- Reset with RESET_OUT=8'hA5 -> out_port=A5, oe=FF, irq=0, read of addr 0 returns A5 one cycle later.
- Write DIR=0F, DATA=FF; drive in_port=30 -> read addr 0 returns 3F after sync latency.
- Write DATA=00, then OUTSET=81, then OUTCLR=01 -> out_port goes 00, then 81, then 80, each on the cycle after its write.
- EDGE_TYPE=0, DIR=00, MASK=04; pulse in_port[2] low→high -> EDGE reads 04 at k+2, irq=1 at k+3. Write EDGE=04 -> irq=0 one cycle later.
- Write EDGE=01 on the same cycle bit 0 sees a new rising edge -> bit 0 remains 1.
- Assert reset_n mid-burst with irq=1 -> irq, readdata and EDGE go to 0 immediately, before any clock edge.
